// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter that shares one single-port on-chip RAM between several Avalon-MM masters.
// The grant and the RAM-side mux are combinational; only the priority pointer and the read-return tag are registered.
module onchip_memory_arbiter #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [DATA_W/8-1:0]           mem_byteenable,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_writedata,
    output logic                          mem_clken,
    input  logic [DATA_W-1:0]             mem_readdata
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       sel;
    logic [IDX_W-1:0]       rd_id;
    logic                   gnt_any;
    logic                   gnt_write;
    logic                   accept;
    logic                   rd_pend;

    // A simultaneous read and write from one master is treated as a write.
    assign req = m_read | m_write;

    // Scan from ptr upwards, wrapping, and take the first requester.
    always_comb begin : grant_scan
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sel     = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            sel = IDX_W'((32'(ptr) + k) % NUM_MASTERS);
            if (!gnt_any && req[sel]) begin
                gnt_any    = 1'b1;
                gnt_idx    = sel;
                grant[sel] = 1'b1;
            end
        end
    end

    // Zero-default AND-OR mux of the granted master onto the RAM port.
    always_comb begin : mem_mux
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        gnt_write      = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                mem_address    = m_address[i*ADDR_W +: ADDR_W];
                mem_byteenable = m_byteenable[i*BE_W +: BE_W];
                mem_writedata  = m_writedata[i*DATA_W +: DATA_W];
                gnt_write      = m_write[i];
            end
        end
    end

    assign accept         = gnt_any & ~reset;
    assign mem_chipselect = accept;
    assign mem_write      = accept & gnt_write;
    assign mem_clken      = 1'b1;
    assign m_waitrequest  = {NUM_MASTERS{reset}} | (req & ~grant);
    assign m_readdata     = mem_readdata;

    // Priority pointer and one-deep read-return tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            rd_pend <= 1'b0;
            rd_id   <= '0;
        end else begin
            rd_pend <= accept & ~gnt_write;
            if (accept) begin
                rd_id <= gnt_idx;
                ptr   <= (gnt_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
        end
    end

    // Return strobe is suppressed while reset is held, even if a read was in flight.
    always_comb begin : rdv_decode
        m_readdatavalid = '0;
        if (rd_pend && !reset) begin
            m_readdatavalid[rd_id] = 1'b1;
        end
    end

endmodule
